// File: rtl/usb_in_arbiter.sv
// usb_in_arbiter: round-robin packet arbiter sharing the USB CDC IN byte stream among NUM_REQ requesters
module usb_in_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int MAX_BURST    = 64,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [8*NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [NUM_REQ-1:0]   req_last_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic [7:0]           in_data_o,
   output logic                 in_valid_o,
   input  logic                 in_ready_i,
   output logic [NUM_REQ-1:0]   grant_o,
   output logic                 busy_o
);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [8:0] MB = 9'(MAX_BURST);
   localparam logic [8:0] IT = 9'(IDLE_TIMEOUT);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state;
   logic [NUM_REQ-1:0] grant_q;
   logic [IW-1:0] last_q, pick;
   logic [7:0] burst_cnt, idle_cnt, in_data_q, sel_data;
   logic [8:0] burst_nxt, idle_nxt;
   logic in_valid_q, accept, sel_last, release_now;

   assign req_ready_o = grant_q & {NUM_REQ{~in_valid_q | in_ready_i}};
   assign accept      = |(req_valid_i & req_ready_o);
   assign sel_last    = |(req_last_i & grant_q);
   assign burst_nxt   = {1'b0, burst_cnt} + 9'd1;
   assign idle_nxt    = {1'b0, idle_cnt} + 9'd1;
   assign release_now = accept ? (sel_last | (burst_nxt >= MB)) : (idle_nxt >= IT);
   assign in_data_o   = in_data_q;
   assign in_valid_o  = in_valid_q;
   assign grant_o     = grant_q;
   assign busy_o      = state == GRANT;

   // Second pass overrides the first, so indices above last_q win over the wrap-around
   always_comb begin
      pick = last_q;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req_valid_i[k] && k <= int'(last_q)) pick = IW'(k);
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req_valid_i[k] && k > int'(last_q)) pick = IW'(k);
   end

   always_comb begin
      sel_data = 8'h00;
      for (int k = 0; k < NUM_REQ; k++)
         sel_data = sel_data | (req_data_i[8*k +: 8] & {8{grant_q[k]}});
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state      <= IDLE;
         grant_q    <= '0;
         last_q     <= IW'(NUM_REQ - 1);
         burst_cnt  <= 8'd0;
         idle_cnt   <= 8'd0;
         in_data_q  <= 8'h00;
         in_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            in_data_q  <= sel_data;
            in_valid_q <= 1'b1;
         end else if (in_ready_i) in_valid_q <= 1'b0;
         if (state == IDLE) begin
            if (|req_valid_i) begin
               state     <= GRANT;
               grant_q   <= NUM_REQ'(1) << pick;
               last_q    <= pick;
               burst_cnt <= 8'd0;
               idle_cnt  <= 8'd0;
            end
         end else if (release_now) begin
            state   <= IDLE;
            grant_q <= '0;
         end else begin
            burst_cnt <= accept ? burst_nxt[7:0] : burst_cnt;
            idle_cnt  <= accept ? 8'd0 : (&idle_cnt ? idle_cnt : idle_nxt[7:0]);
         end
      end
   end
endmodule

// File: tb/tb_usb_in_arbiter.sv
// tb_usb_in_arbiter: table-driven packets plus hand-written corner sequences, checked by an output scoreboard
module tb_usb_in_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [15:0] req_data;
   logic [1:0] req_valid, req_last, req_ready, grant;
   logic [7:0] in_data;
   logic in_valid, busy;
   logic in_ready = 1'b1;
   logic take0, take1;
   logic [8:0] src0[$], src1[$];
   logic [7:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         who;
      int         len;
      logic [7:0] base;
      logic [1:0] grant;
   } vec_t;
   vec_t vecs[5];

   usb_in_arbiter #(.NUM_REQ(2), .MAX_BURST(4), .IDLE_TIMEOUT(16)) dut (
      .clk_i(clk), .reset_i(reset), .req_data_i(req_data), .req_valid_i(req_valid),
      .req_last_i(req_last), .req_ready_o(req_ready), .in_data_o(in_data),
      .in_valid_o(in_valid), .in_ready_i(in_ready), .grant_o(grant), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_pkt(input int who, input logic [7:0] base, input int len, input bit last);
      for (int i = 0; i < len; i++) begin
         logic [8:0] e;
         e = {last && i == len - 1, base + 8'(i)};
         if (who == 0) src0.push_back(e);
         else src1.push_back(e);
      end
   endtask

   task automatic expect_bytes(input logic [7:0] base, input int len);
      for (int i = 0; i < len; i++) exp_q.push_back(base + 8'(i));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         done = exp_q.size() == 0 && src0.size() == 0 && src1.size() == 0 && !in_valid && grant == 2'b00;
      end
      check(name, 32'(done), 32'd1);
   endtask

   // Requester model: present queue heads, pop whatever the DUT took at the edge
   initial begin
      req_valid = 2'b00;
      req_data  = 16'h0;
      req_last  = 2'b00;
      forever begin
         @(negedge clk);
         take0 = req_valid[0] & req_ready[0] & ~reset;
         take1 = req_valid[1] & req_ready[1] & ~reset;
         @(posedge clk);
         #2;
         if (take0 && src0.size() > 0) void'(src0.pop_front());
         if (take1 && src1.size() > 0) void'(src1.pop_front());
         req_valid[0] = src0.size() > 0;
         req_valid[1] = src1.size() > 0;
         {req_last[0], req_data[7:0]}  = src0.size() > 0 ? src0[0] : 9'h0;
         {req_last[1], req_data[15:8]} = src1.size() > 0 ? src1[0] : 9'h0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!reset && in_valid && in_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", in_data);
         end else check("out_byte", 32'(in_data), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1, 1, 8'h80, 2'b10};
      vecs[1] = '{0, 2, 8'h88, 2'b01};
      vecs[2] = '{1, 3, 8'h90, 2'b10};
      vecs[3] = '{0, 4, 8'hC0, 2'b01};
      vecs[4] = '{1, 4, 8'hD0, 2'b10};
      repeat (2) step();
      @(negedge clk);
      check("rst_in_valid", 32'(in_valid), 32'd0);
      check("rst_in_data", 32'(in_data), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      step();
      reset = 1'b0;
      // Contention from reset: req0 first, then req1, then rotation back to req0
      step();
      push_pkt(0, 8'h10, 2, 1);
      push_pkt(1, 8'h20, 2, 1);
      expect_bytes(8'h10, 2);
      expect_bytes(8'h20, 2);
      @(negedge clk);
      @(negedge clk);
      check("cont_grant", 32'(grant), 32'd1);
      wait_drain("cont_drain", 40);
      step();
      push_pkt(0, 8'h12, 1, 1);
      push_pkt(1, 8'h22, 1, 1);
      expect_bytes(8'h12, 1);
      expect_bytes(8'h22, 1);
      @(negedge clk);
      @(negedge clk);
      check("rot_grant", 32'(grant), 32'd1);
      wait_drain("rot_drain", 40);
      // Single requester, cycle by cycle
      step();
      push_pkt(0, 8'hA1, 3, 1);
      expect_bytes(8'hA1, 3);
      @(negedge clk);
      check("s_arb_grant", 32'(grant), 32'd0);
      check("s_arb_valid", 32'(in_valid), 32'd0);
      @(negedge clk);
      check("s_grant", 32'(grant), 32'd1);
      check("s_busy", 32'(busy), 32'd1);
      check("s_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("s_a1", 32'(in_data), 32'hA1);
      @(negedge clk);
      check("s_a2", 32'(in_data), 32'hA2);
      @(negedge clk);
      check("s_a3", 32'(in_data), 32'hA3);
      check("s_a3_valid", 32'(in_valid), 32'd1);
      check("s_release", 32'(grant), 32'd0);
      check("s_busy_off", 32'(busy), 32'd0);
      wait_drain("s_drain", 20);
      for (int v = 0; v < 5; v++) begin
         step();
         push_pkt(vecs[v].who, vecs[v].base, vecs[v].len, 1);
         expect_bytes(vecs[v].base, vecs[v].len);
         @(negedge clk);
         @(negedge clk);
         check("tbl_grant", 32'(grant), 32'(vecs[v].grant));
         wait_drain("tbl_drain", 30);
         check("tbl_busy", 32'(busy), 32'd0);
      end
      // Backpressure: hold in_ready low for 5 cycles after E1 is shown
      step();
      push_pkt(0, 8'hE0, 6, 1);
      expect_bytes(8'hE0, 6);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (in_valid && in_data == 8'hE1) break;
      end
      check("bp_seen_e1", 32'(in_data), 32'hE1);
      step();
      in_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(in_valid), 32'd1);
         check("bp_data", 32'(in_data), 32'hE2);
         check("bp_ready", 32'(req_ready), 32'd0);
      end
      step();
      in_ready = 1'b1;
      wait_drain("bp_drain", 40);
      // Burst limit: req1 streams 6 unterminated bytes, req0 cuts in after 4
      step();
      push_pkt(1, 8'h30, 6, 0);
      push_pkt(0, 8'h40, 2, 1);
      expect_bytes(8'h30, 4);
      expect_bytes(8'h40, 2);
      expect_bytes(8'h34, 2);
      @(negedge clk);
      @(negedge clk);
      check("burst_grant", 32'(grant), 32'd2);
      wait_drain("burst_drain", 100);
      // Idle timeout: byte accepted in cycle 1, grant held through cycle 17
      step();
      push_pkt(0, 8'h55, 1, 0);
      push_pkt(1, 8'h56, 1, 1);
      expect_bytes(8'h55, 2);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (n == 17) check("to_held", 32'(grant), 32'd1);
         if (n == 18) check("to_release", 32'(grant), 32'd0);
         if (n == 19) check("to_next", 32'(grant), 32'd2);
      end
      wait_drain("to_drain", 40);
      // Reset mid-packet with a byte stuck in the output register
      step();
      in_ready = 1'b0;
      push_pkt(0, 8'h50, 4, 1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("rm_valid", 32'(in_valid), 32'd1);
      check("rm_data", 32'(in_data), 32'h50);
      step();
      reset = 1'b1;
      src0.delete();
      step();
      reset = 1'b0;
      @(negedge clk);
      check("rm_valid_off", 32'(in_valid), 32'd0);
      check("rm_data_off", 32'(in_data), 32'd0);
      check("rm_grant", 32'(grant), 32'd0);
      check("rm_busy", 32'(busy), 32'd0);
      step();
      in_ready = 1'b1;
      push_pkt(0, 8'h60, 1, 1);
      push_pkt(1, 8'h70, 1, 1);
      expect_bytes(8'h60, 1);
      expect_bytes(8'h70, 1);
      @(negedge clk);
      @(negedge clk);
      check("rm_regrant", 32'(grant), 32'd1);
      wait_drain("rm_drain", 40);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
